// File: rtl/led_count_ctrl.sv
// led_count_ctrl: run/mode/speed controller for the 4-bit LED counter.
// Two debounced pushbuttons drive a small FSM. A prescaler, whose period is
// set by speed, paces the count in up, down or bounce (ping-pong) mode.

// Per-button front end: 2-FF synchronizer, stability filter and press pulse.
module led_count_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                level      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // Only the rising edge of the filtered level counts as a press
    assign press = level & ~level_d;
endmodule

module led_count_ctrl #(
    parameter int BASE_PERIOD     = 50000000,
    parameter int DIV_WIDTH       = 26,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic [1:0] speed,
    output logic [3:0] count,
    output logic       tick,
    output logic       running,
    output logic [1:0] mode
);
    typedef enum logic [2:0] {
        PAUSED,
        RUN_UP,
        RUN_DOWN,
        BOUNCE_UP,
        BOUNCE_DOWN
    } state_t;

    localparam logic [DIV_WIDTH-1:0] LIMIT0 = DIV_WIDTH'(BASE_PERIOD - 1);
    localparam logic [DIV_WIDTH-1:0] LIMIT1 = DIV_WIDTH'(BASE_PERIOD / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] LIMIT2 = DIV_WIDTH'(BASE_PERIOD / 4 - 1);
    localparam logic [DIV_WIDTH-1:0] LIMIT3 = DIV_WIDTH'(BASE_PERIOD / 8 - 1);

    state_t               state;
    state_t               state_next;
    state_t               eff_state;
    logic [3:0]           count_next;
    logic [1:0]           mode_next;
    logic                 tick_next;
    logic                 running_next;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [DIV_WIDTH-1:0] prescaler_next;
    logic [DIV_WIDTH-1:0] limit;
    logic                 terminal;
    logic                 run_press;
    logic                 mode_press;

    led_count_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .press (run_press)
    );

    led_count_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    // Running state entered for a mode; bounce starts downward only from the top
    function automatic state_t entry_state(input logic [1:0] m, input logic [3:0] c);
        case (m)
            2'd1:    return RUN_DOWN;
            2'd2:    return (c == 4'd15) ? BOUNCE_DOWN : BOUNCE_UP;
            default: return RUN_UP;
        endcase
    endfunction

    // Terminal prescaler value for the current speed setting
    always_comb begin
        case (speed)
            2'd0:    limit = LIMIT0;
            2'd1:    limit = LIMIT1;
            2'd2:    limit = LIMIT2;
            default: limit = LIMIT3;
        endcase
    end

    // >= rather than == so a shortened period never has to wrap the counter
    assign terminal = (prescaler >= limit);

    // Next state: mode press first, then run toggle, then prescaler/count step
    always_comb begin
        state_next     = state;
        eff_state      = state;
        count_next     = count;
        mode_next      = mode;
        prescaler_next = prescaler;
        tick_next      = 1'b0;

        if (mode_press) begin
            mode_next = (mode == 2'd2) ? 2'd0 : mode + 2'd1;
        end
        if (state != PAUSED && mode_press) begin
            eff_state = entry_state(mode_next, count);
        end

        if (state == PAUSED) begin
            if (run_press) begin
                state_next = entry_state(mode_next, count);
            end
        end else if (run_press) begin
            state_next = PAUSED;
        end else begin
            state_next = eff_state;
            if (terminal) begin
                prescaler_next = '0;
                tick_next      = 1'b1;
                case (eff_state)
                    RUN_UP:   count_next = count + 4'd1;
                    RUN_DOWN: count_next = count - 4'd1;
                    BOUNCE_UP: begin
                        if (count == 4'd15) begin
                            count_next = 4'd14;
                            state_next = BOUNCE_DOWN;
                        end else begin
                            count_next = count + 4'd1;
                        end
                    end
                    BOUNCE_DOWN: begin
                        if (count == 4'd0) begin
                            count_next = 4'd1;
                            state_next = BOUNCE_UP;
                        end else begin
                            count_next = count - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                prescaler_next = prescaler + DIV_WIDTH'(1);
            end
        end
    end

    assign running_next = (state_next != PAUSED);

    // All outputs and control state are registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PAUSED;
            count     <= 4'd0;
            mode      <= 2'd0;
            prescaler <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            mode      <= mode_next;
            prescaler <= prescaler_next;
            tick      <= tick_next;
            running   <= running_next;
        end
    end
endmodule

// File: tb/tb_led_count_ctrl.sv
// tb_led_count_ctrl: scenario tasks plus randomized traffic, each checked
// against a behavioural model built from button-sample windows and a
// count/direction/period abstraction.
module tb_led_count_ctrl;
    localparam int BP = 16;
    localparam int N  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run;
    logic       btn_mode;
    logic [1:0] speed;
    logic [3:0] count;
    logic       tick;
    logic       running;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_count, m_mode, m_presc, m_dir;
    bit m_running, m_tick;
    bit m_lvl [2];
    bit m_pend [2];
    bit hist [2][N+2];

    led_count_ctrl #(.BASE_PERIOD(BP), .DIV_WIDTH(5), .DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_mode (btn_mode),
        .speed    (speed),
        .count    (count),
        .tick     (tick),
        .running  (running),
        .mode     (mode)
    );

    // free-running clock
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_count = 0; m_mode = 0; m_presc = 0; m_dir = 1;
        m_running = 0; m_tick = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 0; m_pend[b] = 0;
            for (int i = 0; i < N + 2; i++) hist[b][i] = 0;
        end
    endfunction

    function automatic void model_enter();
        if (m_mode == 1 || (m_mode == 2 && m_count == 15)) m_dir = -1;
        else m_dir = 1;
    endfunction

    function automatic void model_advance();
        if (m_mode == 2) begin
            if (m_count + m_dir > 15 || m_count + m_dir < 0) m_dir = -m_dir;
            m_count = m_count + m_dir;
        end else begin
            m_count = (m_count + m_dir + 16) % 16;
        end
    endfunction

    function automatic void model_step();
        bit press [2];
        bit raw [2];
        bit all_diff;
        int period;
        raw[0] = btn_run;
        raw[1] = btn_mode;
        for (int b = 0; b < 2; b++) begin
            press[b]  = m_pend[b];
            m_pend[b] = 0;
            for (int i = 0; i < N + 1; i++) hist[b][i] = hist[b][i+1];
            hist[b][N+1] = raw[b];
            all_diff = 1;
            for (int i = 0; i < N; i++) if (hist[b][i] == m_lvl[b]) all_diff = 0;
            if (all_diff) begin
                m_lvl[b]  = !m_lvl[b];
                m_pend[b] = m_lvl[b];
            end
        end
        m_tick = 0;
        if (press[1]) begin
            m_mode = (m_mode + 1) % 3;
            if (m_running) model_enter();
        end
        if (press[0]) begin
            if (m_running) m_running = 0;
            else begin m_running = 1; model_enter(); end
        end else if (m_running) begin
            period = BP >> speed;
            if (m_presc >= period - 1) begin
                m_presc = 0; m_tick = 1; model_advance();
            end else begin
                m_presc++;
            end
        end
    endfunction

    function automatic logic [7:0] exp_out();
        return {4'(m_count), m_tick, m_running, 2'(m_mode)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        btn_run = 0; btn_mode = 0; reset = 0;
        model_reset();
        repeat (2) cycle();
        reset = 1;
    endtask

    task automatic test_reset();
        btn_run = 0; btn_mode = 0; speed = 0; reset = 1;
        #3 reset = 0; model_reset();
        #1;
        total++;
        if ({count, tick, running, mode} !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_async got=%h want=00", {count, tick, running, mode});
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL reset_hold got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL reset_idle got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
    endtask

    task automatic test_run_press();
        bit seen_wrap = 0;
        int last_tick = -1;
        logic [3:0] prev = 4'd0;
        do_reset();
        btn_run = 1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            total++;
            if (running !== (i >= 7)) begin
                bad++; $display("[TB] FAIL run_latency edge=%0d got=%b want=%b", i, running, (i >= 7));
            end
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL run_hold got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
        btn_run = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL run_up got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
            if (tick === 1'b1) begin
                if (prev == 4'd15 && count == 4'd0) seen_wrap = 1;
                if (last_tick >= 0) begin
                    total++;
                    if (i - last_tick != BP) begin
                        bad++; $display("[TB] FAIL tick_period got=%0d want=%0d", i - last_tick, BP);
                    end
                end
                last_tick = i;
            end
            prev = count;
        end
        total++;
        if (seen_wrap !== 1'b1) begin
            bad++; $display("[TB] FAIL count_wrap got=%b want=1", seen_wrap);
        end
    endtask

    task automatic test_glitch();
        bit pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int rises = 0;
        bit prev_run = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            btn_run = (i < 3);
            cycle();
            total++;
            if (running !== 1'b0 || {count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL short_pulse got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
        for (int i = 0; i < 32; i++) begin
            btn_run = (i < 8) ? pat[i] : (i < 22);
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL bouncy_btn got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        total++;
        if (rises !== 1 || running !== 1'b1) begin
            bad++; $display("[TB] FAIL bouncy_accept got rises=%0d running=%b want rises=1 running=1", rises, running);
        end
    endtask

    task automatic test_speed();
        bit found = 0;
        do_reset();
        speed = 0;
        btn_run = 1;
        for (int i = 0; i < 100 && !found; i++) begin
            if (i == 8) btn_run = 0;
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL speed_pre got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
            if (i >= 8 && m_running && m_presc == 10) found = 1;
        end
        btn_run = 0;
        total++;
        if (found !== 1'b1) begin
            bad++; $display("[TB] FAIL speed_wait got=timeout want=prescaler 10");
        end
        speed = 3;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            total++;
            if (tick !== (i % 2 == 1) || {count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL speed_fast i=%0d got=%h want=%h", i, {count, tick, running, mode}, exp_out());
            end
        end
        speed = 0;
    endtask

    task automatic test_pause_mode();
        bit found = 0;
        int resume_at = -1;
        int gap = -1;
        do_reset();
        speed = 0;
        btn_run = 1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (i == 8) btn_run = 0;
            cycle();
            if (i >= 8 && m_running && m_count == 5 && m_presc == 3) found = 1;
        end
        total++;
        if (found !== 1'b1) begin
            bad++; $display("[TB] FAIL pause_wait got=timeout want=count 5");
        end
        for (int i = 0; i < 16; i++) begin
            btn_run = (i < 8);
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL pause_press got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
        total++;
        if ({count, running} !== {4'd5, 1'b0}) begin
            bad++; $display("[TB] FAIL pause_state got=%h/%b want=5/0", count, running);
        end
        for (int i = 0; i < 16; i++) begin
            btn_mode = (i < 8);
            cycle();
            total++;
            if (tick !== 1'b0 || count !== 4'd5) begin
                bad++; $display("[TB] FAIL paused_quiet got tick=%b count=%0d want tick=0 count=5", tick, count);
            end
        end
        total++;
        if (mode !== 2'd1 || running !== 1'b0) begin
            bad++; $display("[TB] FAIL paused_mode got=%0d/%b want=1/0", mode, running);
        end
        btn_run = 1;
        for (int i = 1; i <= 40 && gap < 0; i++) begin
            if (i == 9) btn_run = 0;
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL resume got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
            if (running === 1'b1 && resume_at < 0) resume_at = i;
            if (tick === 1'b1) begin
                gap = i - resume_at;
                total++;
                if (count !== 4'd4) begin
                    bad++; $display("[TB] FAIL resume_count got=%0d want=4", count);
                end
            end
        end
        btn_run = 0;
        // held prescaler is 9, so 16-9 running edges remain until the tick
        total++;
        if (gap !== BP - 9) begin
            bad++; $display("[TB] FAIL resume_gap got=%0d want=%0d", gap, BP - 9);
        end
    endtask

    task automatic test_bounce();
        bit found = 0;
        int ticks = 0;
        int v = 13;
        int d = 1;
        do_reset();
        speed = 0;
        btn_run = 1;
        for (int i = 0; i < 400 && !found; i++) begin
            if (i == 8) btn_run = 0;
            cycle();
            if (i >= 8 && m_running && m_tick && m_count == 13) found = 1;
        end
        total++;
        if (found !== 1'b1) begin
            bad++; $display("[TB] FAIL bounce_wait got=timeout want=count 13");
        end
        for (int i = 0; i < 16; i++) begin
            btn_run = (i < 8);
            cycle();
        end
        for (int i = 0; i < 32; i++) begin
            btn_mode = ((i % 16) < 8);
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL bounce_setup got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
        end
        total++;
        if ({count, running, mode} !== {4'd13, 1'b0, 2'd2}) begin
            bad++; $display("[TB] FAIL bounce_armed got=%0d/%b/%0d want=13/0/2", count, running, mode);
        end
        speed = 3;
        btn_run = 1;
        for (int i = 0; i < 120 && ticks < 20; i++) begin
            if (i == 8) btn_run = 0;
            cycle();
            total++;
            if ({count, tick, running, mode} !== exp_out()) begin
                bad++; $display("[TB] FAIL bounce_run got=%h want=%h", {count, tick, running, mode}, exp_out());
            end
            if (tick === 1'b1) begin
                if (v + d > 15 || v + d < 0) d = -d;
                v = v + d;
                ticks++;
                total++;
                if (count !== 4'(v) || mode !== 2'd2) begin
                    bad++; $display("[TB] FAIL bounce_seq n=%0d got=%0d/%0d want=%0d/2", ticks, count, mode, v);
                end
            end
        end
        btn_run = 0;
        total++;
        if (ticks !== 20) begin
            bad++; $display("[TB] FAIL bounce_ticks got=%0d want=20", ticks);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int ticks = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            if (m_running && m_mode == 2 && m_dir < 0 && m_count == 7) found = 1;
        end
        total++;
        if (found !== 1'b1 || count !== 4'd7) begin
            bad++; $display("[TB] FAIL midreset_wait got=%0d want=7 descending", count);
        end
        #2 reset = 0;
        model_reset();
        #1;
        total++;
        if ({count, tick, running, mode} !== 8'h00) begin
            bad++; $display("[TB] FAIL midreset_async got=%h want=00", {count, tick, running, mode});
        end
        cycle();
        reset = 1;
        btn_run = 1;
        for (int i = 0; i < 40 && ticks < 3; i++) begin
            if (i == 8) btn_run = 0;
            cycle();
            if (tick === 1'b1) begin
                ticks++;
                total++;
                if (count !== 4'(ticks) || mode !== 2'd0) begin
                    bad++; $display("[TB] FAIL midreset_restart got=%0d/%0d want=%0d/0", count, mode, ticks);
                end
            end
        end
        btn_run = 0;
        total++;
        if (ticks !== 3) begin
            bad++; $display("[TB] FAIL midreset_ticks got=%0d want=3", ticks);
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            btn_run  = 1'($urandom_range(0, 1));
            btn_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) speed = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                cycle();
                total++;
                if ({count, tick, running, mode} !== exp_out()) begin
                    bad++; $display("[TB] FAIL random seg=%0d got=%h want=%h", seg, {count, tick, running, mode}, exp_out());
                end
            end
        end
        btn_run = 0;
        btn_mode = 0;
    endtask

    // scenario sequence
    initial begin
        btn_run = 0; btn_mode = 0; speed = 0; reset = 1;
        test_reset();
        test_run_press();
        test_glitch();
        test_speed();
        test_pause_mode();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
